sa_ctrl: RTL
============

// Module: sa_ctrl
// PURPOSE
//  Sequencer for the 4x8 SA processing-element array. Accepts one job (operand
//  pair selection + accumulation length) through a start/busy/done handshake.
//  Drives the shared PE control bus: select_m0..3, select0, select1, plus a PE
//  accumulator clear. Flags when the out11..out48 results are valid.
//  Sits beside SA at the same hierarchy level; all SA PEs share its outputs.
// PARAMETERS
//  CNT_W     4  width of k_len and of the internal cycle counter (max k = 2^CNT_W-1)
//  PIPE_LAT  2  PE multiply/accumulate pipeline depth; drain cycles before results are valid
// PORTS
//  clk        in   1      system clock, rising edge
//  reset_n    in   1      synchronous active-low reset
//  start      in   1      job request; sampled only in IDLE
//  abort      in   1      cancel the current job; return to IDLE
//  k_len      in   CNT_W  number of multiply-accumulate cycles for the job; latched at start
//  mode       in   2      operand-pair select; latched at start; one-hot decoded to select_m*
//  busy       out  1      high from the cycle after accept until DONE inclusive
//  done       out  1      1-cycle pulse in DONE
//  out_valid  out  1      1-cycle pulse, coincident with done; SA outputs are stable
//  err        out  1      1-cycle pulse when start is rejected (k_len==0)
//  pe_clr_n   out  1      active-low PE accumulator clear (PE reset_n input = reset_n & pe_clr_n)
//  select_m0  out  1      operand mux select, mode==0
//  select_m1  out  1      operand mux select, mode==1
//  select_m2  out  1      operand mux select, mode==2
//  select_m3  out  1      operand mux select, mode==3
//  select0    out  1      PE accumulator control, LSB
//  select1    out  1      PE accumulator control, MSB
// BEHAVIOUR
//  - All outputs are registered. Each output value applies in the cycle its state is
//    active. Reset values: busy=done=out_valid=err=0, pe_clr_n=1, all select_*=0,
//    state=IDLE, counter=0.
//  - Accumulator codes {select1,select0}: 00=HOLD, 01=LOAD (acc<=product),
//    10=ACC (acc<=acc+product), 11=never driven.
//  - select_m*: one-hot of the latched mode during LOAD/ACC; all 0 in every other state.
//  - FSM states and transitions:
//    IDLE : start & k_len!=0 -> CLEAR; latch k_len and mode.
//           start & k_len==0 -> stay in IDLE; err=1 for the next cycle.
//    CLEAR: pe_clr_n=0 for 1 cycle -> LOAD.
//    LOAD : code 01; cnt<=1. If k_len==1 -> DRAIN, else -> ACC.
//    ACC  : code 10; cnt++. When cnt==k_len-1 in this cycle -> DRAIN.
//           LOAD+ACC together last exactly k_len cycles.
//    DRAIN: code 00 for PIPE_LAT cycles (counter reused, reset on entry) -> DONE.
//    DONE : done=out_valid=1, code 00 -> IDLE.
//  - Latency: start is sampled at edge T. DONE is active in cycle T+2+k_len+PIPE_LAT.
//    The next start can be accepted in cycle T+3+k_len+PIPE_LAT (back-to-back, no bubble).
//  - busy=1 in CLEAR, LOAD, ACC, DRAIN and DONE. start is ignored while busy
//    (no err, no queueing).
//  - abort in any non-IDLE state: next cycle is IDLE, all selects=0, pe_clr_n=1,
//    no done/out_valid. abort has priority over every transition. abort in IDLE
//    has no effect. If start and abort are both high in IDLE, start wins.
//  - reset_n low mid-job: next cycle matches the reset values. The partial job is lost.
//  - k_len=2^CNT_W-1 must not overflow: the counter is CNT_W bits and never exceeds k_len.
//  - Changes to k_len or mode after accept have no effect on the running job.
// STRUCTURE
//  - sa_pkg: state enum {IDLE,CLEAR,LOAD,ACC,DRAIN,DONE}, accumulator codes
//    ACC_HOLD/ACC_LOAD/ACC_ACC, mode-to-one-hot function.
//  - Sub-module sa_cycle_cnt: loadable CNT_W up-counter with clear and terminal-compare
//    output. It is shared by the ACC and DRAIN phases.
//  - Top level: FSM, registered output decode, job latches.
// TESTING
//  1. Reset: hold reset_n=0 for 3 cycles -> all outputs are at their reset values,
//     busy=0, pe_clr_n=1.
//  2. start, k_len=4, mode=2 -> 1 CLEAR cycle (pe_clr_n=0); then select_m2=1 for
//     4 cycles with codes 01,10,10,10; then 2 cycles of 00; done=out_valid=1 at
//     cycle T+8.
//  3. k_len=1, mode=0 -> a single LOAD cycle (code 01, select_m0=1), no ACC; done at T+5.
//  4. k_len=0 start -> err pulses once, busy stays 0, no selects toggle.
//     Then k_len=15 -> exactly 15 LOAD/ACC cycles, no counter wrap.
//  5. abort asserted on the 3rd ACC cycle -> IDLE next cycle, selects=0, done never
//     pulses. A subsequent start runs normally.
//  6. start held high continuously with k_len=2 -> jobs run back-to-back; start
//     is ignored while busy; done pulses every 7 cycles; mode changes mid-job are ignored.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types for the SA array sequencer: FSM states, PE accumulator codes
// and the mode-to-operand-select decode.
package sa_pkg;

    localparam int CNT_W_DEF    = 4;
    localparam int PIPE_LAT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        ACC,
        DRAIN,
        DONE
    } state_t;

    // {select1, select0} as seen by every PE accumulator
    typedef enum logic [1:0] {
        ACC_HOLD = 2'b00,
        ACC_LOAD = 2'b01,
        ACC_ACC  = 2'b10
    } acc_code_t;

    function automatic logic [3:0] mode_onehot(input logic [1:0] mode);
        mode_onehot = 4'b0001 << mode;
    endfunction

endpackage

// File: rtl/sa_ctrl_if.sv
// Job handshake and shared PE control bus between the requester and sa_ctrl.
interface sa_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] k_len;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic             out_valid;
    logic             err;
    logic             pe_clr_n;
    logic             select_m0;
    logic             select_m1;
    logic             select_m2;
    logic             select_m3;
    logic             select0;
    logic             select1;

    modport master (
        output start, abort, k_len, mode,
        input  busy, done, out_valid, err, pe_clr_n,
        input  select_m0, select_m1, select_m2, select_m3, select0, select1
    );

    modport slave (
        input  start, abort, k_len, mode,
        output busy, done, out_valid, err, pe_clr_n,
        output select_m0, select_m1, select_m2, select_m3, select0, select1
    );

endinterface

// File: rtl/sa_cycle_cnt.sv
// Loadable up-counter with clear and terminal-compare, shared by the ACC and
// DRAIN phases of the sequencer.
module sa_cycle_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] term_val,
    output logic             term
);

    logic [CNT_W-1:0] cnt;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == term_val);

endmodule

// File: rtl/sa_ctrl.sv
// Sequencer for the 4x8 SA PE array: runs one CLEAR/LOAD/ACC/DRAIN/DONE job per
// accepted start and drives the shared, fully registered PE control bus.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input logic       clk,
    input logic       reset_n,
    sa_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           state, next_state;
    logic [CNT_W-1:0] k_q;
    logic [1:0]       mode_q;
    logic             accept, reject;
    logic             cnt_clr, cnt_load, cnt_inc, cnt_term;
    logic [CNT_W-1:0] term_val;
    acc_code_t        code_d;
    logic [3:0]       sel_m_d;

    logic             busy_q, done_q, err_q, pe_clr_n_q;
    logic [1:0]       code_q;
    logic [3:0]       sel_m_q;

    assign accept   = (state == IDLE) && bus.start && (bus.k_len != '0);
    assign reject   = (state == IDLE) && bus.start && (bus.k_len == '0);
    assign term_val = (state == DRAIN) ? DRAIN_LAST : k_q - ONE;

    sa_cycle_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .load_val (ONE),
        .term_val (term_val),
        .term     (cnt_term)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: job parameters are only read after accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            k_q    <= bus.k_len;
            mode_q <= bus.mode;
        end
    end

    // NOTE: every signal gets its default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b1;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE:  if (accept) next_state = CLEAR;
            CLEAR: next_state = LOAD;
            LOAD: begin
                if (k_q == ONE) begin
                    next_state = DRAIN;
                end else begin
                    next_state = ACC;
                    cnt_clr    = 1'b0;
                    cnt_load   = 1'b1;
                end
            end
            ACC: begin
                if (cnt_term) begin
                    next_state = DRAIN;
                end else begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_term) begin
                    next_state = DONE;
                end else begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // abort overrides every transition out of a running job
        if (state != IDLE && bus.abort) begin
            next_state = IDLE;
            cnt_clr    = 1'b1;
            cnt_load   = 1'b0;
            cnt_inc    = 1'b0;
        end
    end

    // Outputs are decoded from next_state so each value lands with its state.
    always_comb begin
        code_d  = ACC_HOLD;
        sel_m_d = 4'b0000;
        if (next_state == LOAD) begin
            code_d  = ACC_LOAD;
            sel_m_d = mode_onehot(mode_q);
        end else if (next_state == ACC) begin
            code_d  = ACC_ACC;
            sel_m_d = mode_onehot(mode_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pe_clr_n_q <= 1'b1;
            code_q     <= ACC_HOLD;
            sel_m_q    <= 4'b0000;
        end else begin
            busy_q     <= (next_state != IDLE);
            done_q     <= (next_state == DONE);
            err_q      <= reject;
            pe_clr_n_q <= (next_state != CLEAR);
            code_q     <= code_d;
            sel_m_q    <= sel_m_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = done_q;
    assign bus.err       = err_q;
    assign bus.pe_clr_n  = pe_clr_n_q;
    assign bus.select0   = code_q[0];
    assign bus.select1   = code_q[1];
    assign bus.select_m0 = sel_m_q[0];
    assign bus.select_m1 = sel_m_q[1];
    assign bus.select_m2 = sel_m_q[2];
    assign bus.select_m3 = sel_m_q[3];

endmodule
